// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the single-bus datapath: bus source offsets,
// memory handshake states and the bus-select width helper.
package bus_datapath_pkg;

  // Non-register bus sources, as offsets above the last general register.
  localparam int SRC_HI  = 0;
  localparam int SRC_LO  = 1;
  localparam int SRC_ZHI = 2;
  localparam int SRC_ZLO = 3;
  localparam int SRC_PC  = 4;
  localparam int SRC_MDR = 5;
  localparam int SRC_IN  = 6;
  localparam int SRC_C   = 7;
  localparam int NUM_SPECIAL_SRC = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Width of the encoded bus select for a given register count.
  function automatic int sel_w(input int num_regs);
    return $clog2(num_regs + NUM_SPECIAL_SRC);
  endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Variable-latency memory handshake: latches the transaction at the request
// edge, waits for an ack, and flags a sticky error after a bounded wait.
module mem_handshake_fsm
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 9,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              start_rd_i,
  input  logic              start_wr_i,
  input  logic              ack_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic              rd_load_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WIDTH-1:0]  mem_wdata_o,
  output logic              mem_busy_o,
  output logic              mem_done_o,
  output logic              mem_err_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Next-state logic: start from IDLE, finish on ack or on timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_wr_i || start_rd_i) begin
          state_d = WAIT;
          we_d    = start_wr_i;
          addr_d  = addr_i;
          data_d  = wdata_i;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (ack_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and latch registers with synchronous clear.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Clear) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_req_o   = (state_q == WAIT);
  assign mem_busy_o  = (state_q == WAIT);
  assign mem_we_o    = (state_q == WAIT) && we_q;
  assign rd_load_o   = (state_q == WAIT) && ack_i && !we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = data_q;
  assign mem_done_o  = done_q;
  assign mem_err_o   = err_q;

endmodule

// File: rtl/bus_datapath_p.sv
// Mini SRC single-bus datapath: register file, special registers, bus mux,
// constant extension and the memory handshake.
module bus_datapath_p
  import bus_datapath_pkg::*;
#(
  parameter int   WIDTH       = 32,
  parameter int   NUM_REGS    = 16,
  parameter int   ADDR_W      = 9,
  parameter int   CONST_W     = 19,
  parameter int   MEM_TIMEOUT = 15,
  localparam int  SEL_W       = sel_w(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic [SEL_W-1:0]    bus_sel,
  input  logic [NUM_REGS-1:0] reg_we,
  input  logic                ba_out,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                y_in,
  input  logic                zhi_in,
  input  logic                zlo_in,
  input  logic                pc_in,
  input  logic                inc_pc,
  input  logic                ir_in,
  input  logic                mar_in,
  input  logic                mdr_in,
  input  logic                inport_in,
  input  logic                outport_in,
  input  logic                mem_rd,
  input  logic                mem_wr,
  input  logic [WIDTH-1:0]    alu_hi,
  input  logic [WIDTH-1:0]    alu_lo,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [WIDTH-1:0]    mem_rdata,
  input  logic                mem_ack,
  output logic [WIDTH-1:0]    bus_out,
  output logic [WIDTH-1:0]    y_out,
  output logic [WIDTH-1:0]    ir_out,
  output logic [WIDTH-1:0]    out_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_busy,
  output logic                mem_done,
  output logic                mem_err
);

  localparam int REG_AW = $clog2(NUM_REGS);

  logic [WIDTH-1:0]  gpr_q [NUM_REGS];
  logic [WIDTH-1:0]  hi_q, lo_q, y_q, zhi_q, zlo_q, ir_q, in_q, out_q;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  mdr_q, mdr_d;
  logic [ADDR_W-1:0] mar_q;
  logic [WIDTH-1:0]  c_ext;
  logic [SEL_W-1:0]  src_off;
  logic              rd_load;

  assign c_ext = {{(WIDTH-CONST_W){ir_q[CONST_W-1]}}, ir_q[CONST_W-1:0]};

  // Bus source mux: general registers first, then the special sources.
  always_comb begin
    bus_out = '0;
    src_off = bus_sel - SEL_W'(NUM_REGS);
    if (int'(bus_sel) < NUM_REGS) begin
      if (!(ba_out && bus_sel == '0)) bus_out = gpr_q[bus_sel[REG_AW-1:0]];
    end else begin
      case (int'(src_off))
        SRC_HI:  bus_out = hi_q;
        SRC_LO:  bus_out = lo_q;
        SRC_ZHI: bus_out = zhi_q;
        SRC_ZLO: bus_out = zlo_q;
        SRC_PC:  bus_out = pc_q;
        SRC_MDR: bus_out = mdr_q;
        SRC_IN:  bus_out = in_q;
        SRC_C:   bus_out = c_ext;
        default: bus_out = '0;
      endcase
    end
  end

  // PC load beats increment; MDR read-ack beats a bus load.
  always_comb begin
    pc_d = pc_q;
    if (pc_in)       pc_d = bus_out;
    else if (inc_pc) pc_d = pc_q + 1'b1;
    mdr_d = mdr_q;
    if (rd_load)     mdr_d = mem_rdata;
    else if (mdr_in) mdr_d = bus_out;
  end

  // General-purpose register file loads from the bus.
  always_ff @(posedge Clock) begin
    // NOTE: the register array is cleared like any other state, since Clear must zero every register.
    if (Clear) begin
      for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we[i]) gpr_q[i] <= bus_out;
      end
    end
  end

  // Special-purpose registers and port registers.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      ir_q  <= '0;
      in_q  <= '0;
      out_q <= '0;
      pc_q  <= '0;
      mdr_q <= '0;
      mar_q <= '0;
    end else begin
      if (hi_in)      hi_q  <= bus_out;
      if (lo_in)      lo_q  <= bus_out;
      if (y_in)       y_q   <= bus_out;
      if (zhi_in)     zhi_q <= alu_hi;
      if (zlo_in)     zlo_q <= alu_lo;
      if (ir_in)      ir_q  <= bus_out;
      if (inport_in)  in_q  <= in_data;
      if (outport_in) out_q <= bus_out;
      if (mar_in)     mar_q <= bus_out[ADDR_W-1:0];
      pc_q  <= pc_d;
      mdr_q <= mdr_d;
    end
  end

  assign y_out    = y_q;
  assign ir_out   = ir_q;
  assign out_data = out_q;

  mem_handshake_fsm #(
    .WIDTH       (WIDTH),
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_fsm (
    .Clock       (Clock),
    .Clear       (Clear),
    .start_rd_i  (mem_rd),
    .start_wr_i  (mem_wr),
    .ack_i       (mem_ack),
    .addr_i      (mar_q),
    .wdata_i     (mdr_q),
    .rd_load_o   (rd_load),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_busy_o  (mem_busy),
    .mem_done_o  (mem_done),
    .mem_err_o   (mem_err)
  );

endmodule
